decoder_stream: RTL and testbench
=================================

// Module: decoder_stream
// PURPOSE
//   Parametrised, registered N-way select decoder for the model computer datapath.
//   Each accepted select code is decoded to a one-hot or thermometer word and queued in a 2-entry output FIFO.
//   Consumers pop decoded words over a valid/ready handshake, so decoding can run ahead of a stalled consumer.
//   Out-of-range codes are flagged, not silently aliased. A saturating error counter records them.
// PARAMETERS
//   SEL_W    3    width of the select code
//   NUM_OUT  8    number of decoded outputs; 1 <= NUM_OUT <= 2**SEL_W
//   ERR_W    8    width of the saturating error counter
// PORTS
//   clk        in   1        rising-edge clock
//   rst_n      in   1        synchronous, active-low reset
//   enable     in   1        1 = input side may accept; 0 = input stalls, output still drains
//   in_valid   in   1        select code present
//   in_ready   out  1        block can accept a code this cycle
//   in_sel     in   SEL_W    select code
//   in_mode    in   1        0 = one-hot, 1 = thermometer; sampled with in_sel
//   out_valid  out  1        FIFO head holds a decoded word
//   out_ready  in   1        consumer takes the head word this cycle
//   out_y      out  NUM_OUT  decoded word at the FIFO head
//   out_err    out  1        head word came from an out-of-range code
//   err_cnt    out  ERR_W    count of accepted out-of-range codes, saturating
// BEHAVIOUR
//   - Reset (rst_n==0 at posedge):
//     - FIFO count=0, out_valid=0, out_y=0, out_err=0, err_cnt=0.
//     - in_ready=0 while rst_n is low; reset wins over every other event in that cycle.
//   - Handshake:
//     - in_ready = rst_n & enable & (count<2), driven from registers only.
//     - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - Decode happens at push time and the result is stored. Let s = in_sel, read as unsigned:
//     - one-hot:     y[i] = (i==s)
//     - thermometer: y[i] = (i<=s)
//     - if s >= NUM_OUT: y = 0 and err = 1; otherwise err = 0.
//   - Latency:
//     - A word pushed at edge t shows out_valid=1 with its out_y/out_err after t, if the FIFO was empty.
//     - There is no combinational in->out path.
//   - FIFO (2 entries, strict order):
//     - push only:   count+1
//     - pop only:    count-1
//     - push and pop on the same edge (count==1): count stays 1, head advances to the new word.
//     - count==2: in_ready=0, no push; a pop that edge frees a slot for the next cycle only (no bypass).
//     - count==0: out_valid=0; out_y and out_err are driven 0.
//     - out_y and out_err hold stable while out_valid=1 and out_ready=0.
//   - err_cnt:
//     - +1 on every push with err=1; saturates at 2**ERR_W-1; never wraps.
//     - Cleared only by reset.
//   - enable:
//     - enable=0 mid-stream: stored words still drain; nothing new is accepted.
//     - A code presented while in_ready=0 is not consumed; the source holds it.
//   - Reset mid-operation: queued words are discarded; the first out_valid comes at least 1 cycle after the first post-reset push.
// TESTING
//   1. Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_y=0, err_cnt=0.
//   2. One-hot, SEL_W=3, NUM_OUT=8, out_ready=1: push sel=0..7 back to back
//      -> out_y = 8'h01,02,04,...,80, each 1 cycle after its push; out_err=0; no bubbles.
//   3. Thermometer: push sel=3, mode=1 -> out_y=8'h0F; push sel=7 -> out_y=8'hFF.
//   4. NUM_OUT=6: push sel=6, then sel=7 -> out_y=0, out_err=1 for both; err_cnt=2.
//   5. ERR_W=2: push 5 out-of-range codes -> err_cnt reads 3 after the 3rd push and stays 3.
//   6. Backpressure: out_ready=0, push sel=1,2,3 ->
//      - in_ready drops after 2 pushes; out_y=8'h02 held stable.
//      - Raise out_ready: pops give 8'h02 then 8'h04; sel=3 is accepted the cycle after the first pop.
//   7. Simultaneous push/pop at count==1 -> count stays 1 and order is preserved.
//   8. enable=0 mid-stream -> drain completes and in_ready=0.
//   9. rst_n pulse with 2 words queued -> out_valid=0 the next cycle and the words are lost.

Source files
------------

// File: rtl/decoder_stream.sv
// decoder_stream
//   Registered N-way select decoder feeding a 2-entry output FIFO.
//   Each accepted select code is decoded at push time, either to a one-hot
//   word or to a thermometer word, and queued. Consumers pop decoded words
//   over valid/ready, so decoding can run ahead of a stalled consumer.
//   Out-of-range codes produce an all-zero word with out_err set and bump a
//   saturating error counter.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   enable     1 = input side may accept; 0 = input stalls, output drains
//   in_valid   select code present
//   in_ready   a code can be accepted this cycle
//   in_sel     select code (unsigned)
//   in_mode    0 = one-hot, 1 = thermometer
//   out_valid  FIFO head holds a decoded word
//   out_ready  consumer takes the head word this cycle
//   out_y      decoded word at the FIFO head (0 when empty)
//   out_err    head word came from an out-of-range code
//   err_cnt    saturating count of accepted out-of-range codes
module decoder_stream #(
    parameter int SEL_W   = 3,
    parameter int NUM_OUT = 8,
    parameter int ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_y,
    output logic               out_err,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Slot 0 is always the head; slot 1 is the word behind it. A slot that
    // holds no word is kept at zero, so out_y/out_err read 0 when empty.
    logic [1:0]         count_q, count_d;
    logic [NUM_OUT-1:0] y0_q, y0_d, y1_q, y1_d;
    logic               err0_q, err0_d, err1_q, err1_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic               push, pop;
    logic [NUM_OUT-1:0] dec_y;
    logic               dec_err;
    int unsigned        sel_u;

    assign in_ready  = rst_n & enable & (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_y   = y0_q;
    assign out_err = err0_q;
    assign err_cnt = err_cnt_q;

    // Decode of the incoming code; only used when it is pushed.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave it
        // unassigned and infer a latch.
        dec_y   = '0;
        dec_err = 1'b0;
        sel_u   = 32'(in_sel);
        if (sel_u >= NUM_OUT) begin
            dec_err = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                dec_y[i] = in_mode ? (i <= sel_u) : (i == sel_u);
            end
        end
    end

    always_comb begin
        count_d   = count_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        err0_d    = err0_q;
        err1_d    = err1_q;
        err_cnt_d = err_cnt_q;

        if (pop) begin
            // Shift the second slot forward and clear the vacated one.
            y0_d   = y1_q;
            err0_d = err1_q;
            y1_d   = '0;
            err1_d = 1'b0;
        end

        // Push lands in the first free slot after any pop on this edge.
        // in_ready already excludes count==2, so a full FIFO never pushes.
        if (push) begin
            if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
                y0_d   = dec_y;
                err0_d = dec_err;
            end else begin
                y1_d   = dec_y;
                err1_d = dec_err;
            end
            if (dec_err && err_cnt_q != ERR_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            // NOTE: the two FIFO slots are reset too; empty slots must read 0
            // and queued words are discarded on reset.
            count_q   <= 2'd0;
            y0_q      <= '0;
            y1_q      <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            count_q   <= count_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_decoder_stream.sv
// Directed bench for decoder_stream: one default instance (SEL_W=3,
// NUM_OUT=8, ERR_W=8) and one narrow instance (NUM_OUT=6, ERR_W=2) for
// the out-of-range and saturation cases.
module tb_decoder_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // default instance
    logic       enable_a = 1'b1, in_valid_a = 1'b0, in_mode_a = 1'b0, out_ready_a = 1'b0;
    logic [2:0] in_sel_a = '0;
    logic       in_ready_a, out_valid_a, out_err_a;
    logic [7:0] out_y_a, err_cnt_a;

    // NUM_OUT=6, ERR_W=2 instance
    logic       enable_b = 1'b1, in_valid_b = 1'b0, in_mode_b = 1'b0, out_ready_b = 1'b1;
    logic [2:0] in_sel_b = '0;
    logic       in_ready_b, out_valid_b, out_err_b;
    logic [5:0] out_y_b;
    logic [1:0] err_cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_stream u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_sel(in_sel_a), .in_mode(in_mode_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_y(out_y_a),
        .out_err(out_err_a), .err_cnt(err_cnt_a)
    );

    decoder_stream #(.SEL_W(3), .NUM_OUT(6), .ERR_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_sel(in_sel_b), .in_mode(in_mode_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_y(out_y_b),
        .out_err(out_err_b), .err_cnt(err_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. reset with in_valid held high
        in_valid_a = 1'b1;
        in_sel_a   = 3'd0;
        repeat (2) tick();
        check("rst_in_ready", 32'(in_ready_a), 0);
        check("rst_out_valid", 32'(out_valid_a), 0);
        check("rst_out_y", 32'(out_y_a), 0);
        check("rst_out_err", 32'(out_err_a), 0);
        check("rst_err_cnt", 32'(err_cnt_a), 0);
        in_valid_a = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(out_valid_a), 0);

        // 2. one-hot, back to back, consumer always ready
        out_ready_a = 1'b1;
        in_mode_a   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid_a = 1'b1;
            in_sel_a   = 3'(i);
            check($sformatf("oh_in_ready_%0d", i), 32'(in_ready_a), 1);
            tick();
            check($sformatf("oh_valid_%0d", i), 32'(out_valid_a), 1);
            check($sformatf("oh_y_%0d", i), 32'(out_y_a), 32'(1) << i);
            check($sformatf("oh_err_%0d", i), 32'(out_err_a), 0);
        end
        in_valid_a = 1'b0;
        tick();
        check("oh_drained", 32'(out_valid_a), 0);
        check("oh_empty_y", 32'(out_y_a), 0);

        // 3. thermometer
        in_mode_a  = 1'b1;
        in_valid_a = 1'b1;
        in_sel_a   = 3'd3;
        tick();
        check("th_sel3", 32'(out_y_a), 32'h0F);
        in_sel_a = 3'd7;
        tick();
        check("th_sel7", 32'(out_y_a), 32'hFF);
        check("th_err", 32'(out_err_a), 0);
        in_valid_a = 1'b0;
        in_mode_a  = 1'b0;
        tick();

        // 4. NUM_OUT=6: codes 6 and 7 are out of range, 5 is the top valid one
        in_valid_b = 1'b1;
        in_sel_b   = 3'd6;
        tick();
        check("b_sel6_y", 32'(out_y_b), 0);
        check("b_sel6_err", 32'(out_err_b), 1);
        check("b_sel6_cnt", 32'(err_cnt_b), 1);
        in_sel_b = 3'd7;
        tick();
        check("b_sel7_y", 32'(out_y_b), 0);
        check("b_sel7_err", 32'(out_err_b), 1);
        check("b_sel7_cnt", 32'(err_cnt_b), 2);
        in_sel_b = 3'd5;
        tick();
        check("b_sel5_y", 32'(out_y_b), 32'h20);
        check("b_sel5_err", 32'(out_err_b), 0);
        check("b_sel5_cnt", 32'(err_cnt_b), 2);
        in_valid_b = 1'b0;

        // 5. ERR_W=2 saturation from a fresh reset
        rst_n = 1'b0;
        tick();
        check("b_rst_cnt", 32'(err_cnt_b), 0);
        rst_n = 1'b1;
        in_valid_b = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_sel_b = (k % 2 == 1) ? 3'd6 : 3'd7;
            tick();
            check($sformatf("b_sat_%0d", k), 32'(err_cnt_b), (k < 3) ? k : 3);
        end
        in_valid_b = 1'b0;
        tick();

        // 6. backpressure: sel=1,2,3 with consumer stalled
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_sel_a    = 3'd1;
        tick();
        in_sel_a = 3'd2;
        check("bp_ready_1", 32'(in_ready_a), 1);
        tick();
        in_sel_a = 3'd3;
        check("bp_ready_full", 32'(in_ready_a), 0);
        check("bp_head", 32'(out_y_a), 32'h02);
        tick();
        check("bp_hold_y", 32'(out_y_a), 32'h02);
        check("bp_hold_ready", 32'(in_ready_a), 0);
        out_ready_a = 1'b1;
        tick();
        check("bp_pop1_y", 32'(out_y_a), 32'h04);
        check("bp_ready_after_pop", 32'(in_ready_a), 1);
        tick();
        check("bp_pop2_y", 32'(out_y_a), 32'h08);
        in_valid_a = 1'b0;
        tick();
        check("bp_drained", 32'(out_valid_a), 0);

        // 7. simultaneous push and pop at count==1
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_sel_a    = 3'd4;
        tick();
        check("pp_first", 32'(out_y_a), 32'h10);
        out_ready_a = 1'b1;
        in_sel_a    = 3'd5;
        tick();
        check("pp_second", 32'(out_y_a), 32'h20);
        check("pp_valid", 32'(out_valid_a), 1);
        in_valid_a = 1'b0;
        tick();
        check("pp_count1", 32'(out_valid_a), 0);

        // 8. enable=0 mid-stream: drain, accept nothing
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_sel_a    = 3'd0;
        tick();
        in_sel_a = 3'd1;
        tick();
        enable_a = 1'b0;
        in_sel_a = 3'd2;
        #1;
        check("en_ready_low", 32'(in_ready_a), 0);
        out_ready_a = 1'b1;
        tick();
        check("en_drain1", 32'(out_y_a), 32'h02);
        tick();
        check("en_drained", 32'(out_valid_a), 0);
        tick();
        check("en_no_accept", 32'(out_valid_a), 0);
        check("en_ready_still_low", 32'(in_ready_a), 0);
        in_valid_a = 1'b0;
        enable_a   = 1'b1;

        // 9. reset pulse with 2 words queued
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        in_sel_a    = 3'd1;
        tick();
        in_sel_a = 3'd2;
        tick();
        in_valid_a = 1'b0;
        rst_n = 1'b0;
        tick();
        check("rp_valid", 32'(out_valid_a), 0);
        check("rp_y", 32'(out_y_a), 0);
        rst_n = 1'b1;
        tick();
        check("rp_lost", 32'(out_valid_a), 0);
        in_valid_a = 1'b1;
        in_sel_a   = 3'd6;
        tick();
        check("rp_new_word", 32'(out_y_a), 32'h40);
        in_valid_a = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
